// File: rtl/vend_sequencer_if.sv
// Bundle of coin, selection, configuration and dispenser/change handshake
// signals between the vending sequencer and its environment.
interface vend_sequencer_if;
  logic       coin1;
  logic       coin2;
  logic       sel_valid;
  logic [1:0] sel_id;
  logic       cancel;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [3:0] cfg_price;
  logic       vend_req;
  logic [1:0] vend_id;
  logic       vend_ack;
  logic       change_req;
  logic       change_ack;
  logic [3:0] credit;
  logic       busy;
  logic       coin_reject;
  logic       sel_err;

  // Sequencer side: consumes coins/selections/acks, drives requests and status.
  modport master (
    input  coin1, coin2, sel_valid, sel_id, cancel,
    input  cfg_we, cfg_addr, cfg_price, vend_ack, change_ack,
    output vend_req, vend_id, change_req, credit, busy, coin_reject, sel_err
  );

  // Environment side: coin acceptor, keypad, config port, dispenser, hopper.
  modport slave (
    output coin1, coin2, sel_valid, sel_id, cancel,
    output cfg_we, cfg_addr, cfg_price, vend_ack, change_ack,
    input  vend_req, vend_id, change_req, credit, busy, coin_reject, sel_err
  );
endinterface

// File: rtl/vend_sequencer.sv
// Vending machine sequencer: accumulates coin credit, checks selections
// against a writable price table, runs the dispense handshake and pays out
// change one rupee at a time. Idle credit is refunded after TIMEOUT cycles.
module vend_sequencer #(
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  vend_sequencer_if.master bus
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CREDIT,
    ST_VEND,
    ST_CHANGE
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      credit_q, credit_d;
  logic [3:0]      price_q [4];
  logic [3:0]      price_d [4];
  logic [1:0]      vend_id_q, vend_id_d;
  logic [3:0]      vend_price_q, vend_price_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            vend_req_q, vend_req_d;
  logic            change_req_q, change_req_d;
  logic            busy_q, busy_d;
  logic            coin_reject_q, coin_reject_d;
  logic            sel_err_q, sel_err_d;

  logic            any_coin;
  logic [1:0]      coin_sum;
  logic [4:0]      credit_sum;
  logic [3:0]      sel_price;
  logic            sel_ok;
  logic [3:0]      credit_rem;
  logic [TW-1:0]   timer_inc;

  assign any_coin   = bus.coin1 | bus.coin2;
  assign coin_sum   = {bus.coin2, bus.coin1};
  assign credit_sum = {1'b0, credit_q} + {3'b000, coin_sum};
  assign sel_price  = price_q[bus.sel_id];
  assign sel_ok     = (sel_price != 4'd0) && (credit_q >= sel_price);
  assign credit_rem = credit_q - vend_price_q;
  assign timer_inc  = timer_q + 1'b1;

  // Next-state, credit bookkeeping, price table update and registered outputs.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    price_d       = price_q;
    vend_id_d     = vend_id_q;
    vend_price_d  = vend_price_q;
    timer_d       = '0;
    coin_reject_d = 1'b0;
    sel_err_d     = 1'b0;

    if (bus.cfg_we) begin
      price_d[bus.cfg_addr] = bus.cfg_price;
    end

    case (state_q)
      ST_IDLE, ST_CREDIT: begin
        if (bus.cancel && (state_q == ST_CREDIT)) begin
          state_d       = ST_CHANGE;
          coin_reject_d = any_coin;
        end else if (bus.sel_valid) begin
          coin_reject_d = any_coin;
          if (sel_ok) begin
            state_d      = ST_VEND;
            vend_id_d    = bus.sel_id;
            vend_price_d = sel_price;
          end else begin
            sel_err_d = 1'b1;
          end
        end else if (any_coin) begin
          if (credit_sum > 5'd15) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = credit_sum[3:0];
            state_d  = ST_CREDIT;
          end
        end else if (!bus.cancel && (state_q == ST_CREDIT)) begin
          if (timer_inc == TW'(TIMEOUT)) begin
            state_d = ST_CHANGE;
          end else begin
            timer_d = timer_inc;
          end
        end
      end
      ST_VEND: begin
        coin_reject_d = any_coin;
        if (bus.vend_ack) begin
          credit_d = credit_rem;
          state_d  = (credit_rem != 4'd0) ? ST_CHANGE : ST_IDLE;
        end
      end
      ST_CHANGE: begin
        coin_reject_d = any_coin;
        if (change_req_q && bus.change_ack) begin
          credit_d = credit_q - 4'd1;
          if (credit_q == 4'd1) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = 4'd0;
      end
    endcase

    vend_req_d   = (state_d == ST_VEND);
    change_req_d = (state_d == ST_CHANGE);
    busy_d       = (state_d == ST_VEND) || (state_d == ST_CHANGE);
  end

  // State and output registers; reset abandons any transaction in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      credit_q      <= 4'd0;
      price_q[0]    <= 4'd2;
      price_q[1]    <= 4'd3;
      price_q[2]    <= 4'd4;
      price_q[3]    <= 4'd5;
      vend_id_q     <= 2'd0;
      vend_price_q  <= 4'd0;
      timer_q       <= '0;
      vend_req_q    <= 1'b0;
      change_req_q  <= 1'b0;
      busy_q        <= 1'b0;
      coin_reject_q <= 1'b0;
      sel_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      price_q       <= price_d;
      vend_id_q     <= vend_id_d;
      vend_price_q  <= vend_price_d;
      timer_q       <= timer_d;
      vend_req_q    <= vend_req_d;
      change_req_q  <= change_req_d;
      busy_q        <= busy_d;
      coin_reject_q <= coin_reject_d;
      sel_err_q     <= sel_err_d;
    end
  end

  assign bus.vend_req    = vend_req_q;
  assign bus.vend_id     = vend_id_q;
  assign bus.change_req  = change_req_q;
  assign bus.credit      = credit_q;
  assign bus.busy        = busy_q;
  assign bus.coin_reject = coin_reject_q;
  assign bus.sel_err     = sel_err_q;

endmodule
